// File: rtl/d_write_buffer.sv
// Posted-write FIFO between the D-cache memory port and the sram-like AXI bridge.
// Optional macro WB_READ_FORWARD_EN: serve word reads straight from a matching buffered word write.
module d_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_req,
  input  logic        wb_wr,
  input  logic [1:0]  wb_size,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  output logic        wb_addr_ok,
  output logic        wb_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_addr  [DEPTH];
  logic [1:0]    r_size  [DEPTH];
  logic [31:0]   r_wdata [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_rdata;

  // Full is judged on the registered count; a same-cycle pop does not help.
  assign w_push = rst & wb_req & wb_wr & (r_count != (AW+1)'(DEPTH));

`ifdef WB_READ_FORWARD_EN
  logic          w_fwd_match;
  logic [AW-1:0] w_fwd_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    w_fwd_match = 1'b0;
    w_fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < r_count) &&
          (r_addr[r_head + AW'(i)][31:2] == wb_addr[31:2])) begin
        w_fwd_match = 1'b1;
        w_fwd_idx   = r_head + AW'(i);
      end
    end
  end

  assign w_fwd_hit = wb_req & ~wb_wr & (wb_size == 2'd2) & w_fwd_match &
                     (r_size[w_fwd_idx] == 2'd2) &
                     (r_state != R_ADDR) & (r_state != R_DATA);
  assign w_fwd_rdata = r_wdata[w_fwd_idx];
`else
  assign w_fwd_hit   = 1'b0;
  assign w_fwd_rdata = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    wb_addr_ok  = w_push;
    wb_data_ok  = w_push;
    wb_rdata    = '0;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_size    = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (w_fwd_hit) begin
      wb_addr_ok = 1'b1;
      wb_data_ok = 1'b1;
      wb_rdata   = w_fwd_rdata;
    end
    case (r_state)
      IDLE: begin
        if ((r_count != '0) || w_push)
          w_state_nxt = W_ADDR;
        else if (wb_req && !wb_wr && !w_fwd_hit)
          w_state_nxt = R_ADDR;
      end
      W_ADDR, W_DATA: begin
        mem_req   = (r_state == W_ADDR);
        mem_wr    = 1'b1;
        mem_size  = r_size[r_head];
        mem_addr  = r_addr[r_head];
        mem_wdata = r_wdata[r_head];
        if (r_state == W_ADDR) begin
          if (mem_addr_ok && mem_data_ok) begin
            w_pop       = 1'b1;
            w_state_nxt = IDLE;
          end else if (mem_addr_ok) begin
            w_state_nxt = W_DATA;
          end
        end else if (mem_data_ok) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      R_ADDR: begin
        mem_req    = 1'b1;
        mem_size   = wb_size;
        mem_addr   = wb_addr;
        wb_addr_ok = mem_addr_ok;
        if (mem_addr_ok && mem_data_ok) begin
          wb_data_ok  = 1'b1;
          wb_rdata    = mem_rdata;
          w_state_nxt = IDLE;
        end else if (mem_addr_ok) begin
          w_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (mem_data_ok) begin
          wb_data_ok  = 1'b1;
          wb_rdata    = mem_rdata;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rst) begin
      w_pop      = 1'b0;
      wb_addr_ok = 1'b0;
      wb_data_ok = 1'b0;
      wb_rdata   = '0;
      mem_req    = 1'b0;
      mem_wr     = 1'b0;
      mem_size   = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail]  <= wb_addr;
      r_size[r_tail]  <= wb_size;
      r_wdata[r_tail] <= wb_wdata;
    end
  end

endmodule

// File: tb/tb_d_write_buffer.sv
// Directed bench for d_write_buffer; the forwarding check follows WB_READ_FORWARD_EN.
module tb_d_write_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req, wb_wr;
  logic [1:0]  wb_size;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic        wb_addr_ok, wb_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  d_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_wr(wb_wr), .wb_size(wb_size), .wb_addr(wb_addr),
    .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_addr_ok(wb_addr_ok),
    .wb_data_ok(wb_data_ok), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    wb_req = 1'b1; wb_wr = 1'b1; wb_addr = a; wb_wdata = d; wb_size = s;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] s);
    wb_req = 1'b1; wb_wr = 1'b0; wb_addr = a; wb_wdata = '0; wb_size = s;
  endtask

  // Immediate-ack bridge; every write seen on mem_req must match the queue head.
  task automatic drain(input int budget);
    logic [63:0] e;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      settle();
      chk("drain_no_wb_ok", {31'b0, wb_addr_ok}, 32'd0);
      if (mem_req) begin
        e = exp_q.pop_front();
        chk("drain_wr", {31'b0, mem_wr}, 32'd1);
        chk("drain_addr", mem_addr, e[63:32]);
        chk("drain_data", mem_wdata, e[31:0]);
      end
      tick();
    end
    chk("drain_all_seen", exp_q.size(), 32'd0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  initial begin
    int wi, k;
    rst = 1'b0; wb_req = 1'b0; wb_wr = 1'b0; wb_size = 2'd0; wb_addr = '0; wb_wdata = '0;
    mem_rdata = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    // Reset: a write presented during reset is not acknowledged.
    wr(32'h0000_0F00, 32'h1, 2'd2);
    tick(); tick(); settle();
    chk("rst_addr_ok", {31'b0, wb_addr_ok}, 32'd0);
    chk("rst_data_ok", {31'b0, wb_data_ok}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_count", {29'b0, dut.r_count}, 32'd0);
    wb_req = 1'b0;
    rst = 1'b1;
    tick();

    // Single write, immediate bridge.
    wr(32'h0000_1000, 32'hDEAD_BEEF, 2'd2);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    settle();
    chk("sw_addr_ok", {31'b0, wb_addr_ok}, 32'd1);
    chk("sw_data_ok", {31'b0, wb_data_ok}, 32'd1);
    chk("sw_idle_mem_req", {31'b0, mem_req}, 32'd0);
    tick();
    wb_req = 1'b0;
    settle();
    chk("sw_mem_req", {31'b0, mem_req}, 32'd1);
    chk("sw_mem_addr", mem_addr, 32'h0000_1000);
    chk("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_mem_size", {30'b0, mem_size}, 32'd2);
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    settle();
    chk("sw_count0", {29'b0, dut.r_count}, 32'd0);
    chk("sw_mem_req_low", {31'b0, mem_req}, 32'd0);
    chk("sw_mem_addr_low", mem_addr, 32'd0);

    // Fill and stall: bridge withholds addr_ok.
    for (int i = 0; i < 5; i++) begin
      wr(32'h100 + 4 * i, 32'hA0 + i, 2'd2);
      settle();
      chk("fill_ack", {31'b0, wb_addr_ok}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    chk("fill_head_addr", mem_addr, 32'h100);
    chk("fill_head_req", {31'b0, mem_req}, 32'd1);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    settle();
    chk("fill_pop_cycle_no_ack", {31'b0, wb_addr_ok}, 32'd0);
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    settle();
    chk("fill_5th_ack", {31'b0, wb_addr_ok}, 32'd1);
    tick();
    wb_req = 1'b0;
    for (int i = 1; i < 5; i++) exp_q.push_back({32'h100 + 4 * i, 32'hA0 + i});
    drain(40);
    settle();
    chk("fill_count0", {29'b0, dut.r_count}, 32'd0);

    // Read after write: the read reaches memory only after the write completes.
    wr(32'h2000, 32'h1122_3344, 2'd2);
    tick();
    rd(32'h2000, 2'd1);
    settle();
    chk("raw_write_first", {31'b0, mem_wr}, 32'd1);
    chk("raw_write_addr", mem_addr, 32'h2000);
    chk("raw_rd_held", {31'b0, wb_addr_ok}, 32'd0);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    settle();
    chk("raw_wdata_no_req", {31'b0, mem_req}, 32'd0);
    mem_data_ok = 1'b1;
    settle();
    chk("raw_wr_no_upstream_ok", {31'b0, wb_data_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b0;
    settle();
    chk("raw_idle_no_req", {31'b0, mem_req}, 32'd0);
    chk("raw_idle_rdata0", wb_rdata, 32'd0);
    tick();
    chk("raw_rd_req", {31'b0, mem_req}, 32'd1);
    chk("raw_rd_wr", {31'b0, mem_wr}, 32'd0);
    chk("raw_rd_addr", mem_addr, 32'h2000);
    chk("raw_rd_size", {30'b0, mem_size}, 32'd1);
    chk("raw_rd_no_ok_yet", {31'b0, wb_addr_ok}, 32'd0);
    mem_addr_ok = 1'b1;
    settle();
    chk("raw_rd_addr_ok", {31'b0, wb_addr_ok}, 32'd1);
    chk("raw_rd_data_ok_early", {31'b0, wb_data_ok}, 32'd0);
    tick();
    wb_req = 1'b0; mem_addr_ok = 1'b0; mem_rdata = 32'h5566_7788;
    settle();
    chk("raw_rdata_wait", {31'b0, wb_data_ok}, 32'd0);
    mem_data_ok = 1'b1;
    settle();
    chk("raw_data_ok", {31'b0, wb_data_ok}, 32'd1);
    chk("raw_rdata", wb_rdata, 32'h5566_7788);
    tick();
    mem_data_ok = 1'b0;
    settle();
    chk("raw_after_rdata0", wb_rdata, 32'd0);

    // Read with empty buffer and a same-cycle bridge response.
    rd(32'h4000, 2'd2);
    settle();
    chk("er_idle_no_req", {31'b0, mem_req}, 32'd0);
    tick();
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    settle();
    chk("er_req", {31'b0, mem_req}, 32'd1);
    chk("er_addr_ok", {31'b0, wb_addr_ok}, 32'd1);
    chk("er_data_ok", {31'b0, wb_data_ok}, 32'd1);
    chk("er_rdata", wb_rdata, 32'hCAFE_F00D);
    tick();
    wb_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    // Forwarding candidates with a stalled bridge.
    wr(32'h3000, 32'hAAAA_0000, 2'd2);
    tick();
    wr(32'h3000, 32'hBBBB_1111, 2'd2);
    tick();
    rd(32'h3000, 2'd2);
    settle();
`ifdef WB_READ_FORWARD_EN
    chk("fwd_addr_ok", {31'b0, wb_addr_ok}, 32'd1);
    chk("fwd_data_ok", {31'b0, wb_data_ok}, 32'd1);
    chk("fwd_rdata", wb_rdata, 32'hBBBB_1111);
`else
    chk("nofwd_addr_ok", {31'b0, wb_addr_ok}, 32'd0);
    chk("nofwd_data_ok", {31'b0, wb_data_ok}, 32'd0);
`endif
    chk("fwd_mem_is_write", {31'b0, mem_wr}, 32'd1);
    tick();
    wr(32'h3004, 32'h0000_00CC, 2'd0);
    tick();
    rd(32'h3004, 2'd2);
    settle();
    chk("sb_rd_held", {31'b0, wb_addr_ok}, 32'd0);
    exp_q.push_back({32'h3000, 32'hAAAA_0000});
    exp_q.push_back({32'h3000, 32'hBBBB_1111});
    exp_q.push_back({32'h3004, 32'h0000_00CC});
    drain(40);
    settle();
    chk("sb_rd_idle_no_req", {31'b0, mem_req}, 32'd0);
    tick();
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0000_00CC;
    settle();
    chk("sb_rd_req", {31'b0, mem_req}, 32'd1);
    chk("sb_rd_addr", mem_addr, 32'h3004);
    chk("sb_rd_data_ok", {31'b0, wb_data_ok}, 32'd1);
    chk("sb_rd_rdata", wb_rdata, 32'h0000_00CC);
    tick();
    wb_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      wr(32'h5000 + 4 * i, 32'h50 + i, 2'd2);
      tick();
    end
    wb_req = 1'b0;
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    settle();
    chk("rmd_wdata_no_req", {31'b0, mem_req}, 32'd0);
    chk("rmd_count3", {29'b0, dut.r_count}, 32'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    chk("rmd_count0", {29'b0, dut.r_count}, 32'd0);
    chk("rmd_mem_req", {31'b0, mem_req}, 32'd0);
    mem_data_ok = 1'b1;
    settle();
    chk("rmd_late_no_data_ok", {31'b0, wb_data_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b0;
    settle();
    chk("rmd_late_no_pop", {29'b0, dut.r_count}, 32'd0);
    chk("rmd_still_idle", {31'b0, mem_req}, 32'd0);

    // Pointer wrap: ten writes through a one-cycle bridge.
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    wi = 0; k = 0;
    for (int c = 0; c < 100 && k < 10; c++) begin
      if (wi < 10) wr(32'h6000 + 4 * wi, 32'h600 + wi, 2'd2);
      else wb_req = 1'b0;
      settle();
      if (mem_req) begin
        chk("wrap_addr", mem_addr, 32'h6000 + 4 * k);
        chk("wrap_data", mem_wdata, 32'h600 + k);
        k++;
      end
      chk("wrap_count_max", {31'b0, dut.r_count <= 3'd4}, 32'd1);
      if (wb_addr_ok) wi++;
      tick();
    end
    wb_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    chk("wrap_writes_acked", wi, 32'd10);
    chk("wrap_writes_seen", k, 32'd10);
    settle();
    chk("wrap_count0", {29'b0, dut.r_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
